// File: rtl/sample_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_sram_arbiter
// Purpose  : On-chip synchronous sample memory shared by NUM_CH requesters.
//            A round-robin arbiter grants at most one valid/ready request per
//            cycle. Writes honour byte enables. Every accepted request gives a
//            one-cycle response pulse on its channel, one cycle later.
//            Writes return the word as it was before the write.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   req_valid  in   [NUM_CH]          per-channel request valid
//   req_ready  out  [NUM_CH]          per-channel grant (one-hot/zero, comb.)
//   req_write  in   [NUM_CH]          1 = write, 0 = read
//   req_addr   in   [NUM_CH*ADDR_W]   packed addresses, ch i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   [NUM_CH*DATA_W]   packed write data
//   req_be     in   [NUM_CH*DATA_W/8] packed byte enables
//   rsp_valid  out  [NUM_CH]          one-hot response pulse, registered
//   rsp_rdata  out  [DATA_W]          response data, qualified by rsp_valid
//   CE         out  registered memory-active strobe
// ============================================================================
module sample_sram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int NUM_CH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] req_be,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       CE
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LG_W  = $clog2(NUM_CH);

  logic [LG_W-1:0]   last_grant;
  logic [LG_W-1:0]   cand;
  logic [LG_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic              accept;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Round-robin search starting one past the last granted channel. Nothing
  // is granted while RESET is high so no access can slip in during reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (!RESET) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = LG_W'((int'(last_grant) + k) % NUM_CH);
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          found       = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign accept    = found;

  // Fields of the granted channel
  assign sel_write = req_write[grant_idx];
  assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];
  assign sel_be    = req_be[grant_idx*BE_W +: BE_W];

  // Sample store: no reset on contents, byte-granular writes.
  always_ff @(posedge CLK) begin
    if (accept && sel_write) begin
      for (int j = 0; j < BE_W; j++) begin
        if (sel_be[j]) begin
          mem[sel_addr][j*8 +: 8] <= sel_wdata[j*8 +: 8];
        end
      end
    end
  end

  // Response path. The read samples the memory before this edge's write
  // lands, which gives read-old-during-write for the write response.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant <= LG_W'(NUM_CH - 1);
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      CE         <= 1'b0;
    end else begin
      rsp_valid <= grant;
      CE        <= accept;
      if (accept) begin
        last_grant <= grant_idx;
        rsp_rdata  <= mem[sel_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_sram_arbiter
// Purpose  : Directed self-checking bench for sample_sram_arbiter
//            (DATA_W=32, ADDR_W=13, NUM_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_sram_arbiter;

  logic         CLK;
  logic         RESET;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_write;
  logic [51:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_be;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         CE;

  int checks;
  int failures;

  sample_sram_arbiter #(
    .DATA_W(32),
    .ADDR_W(13),
    .NUM_CH(4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .CE        (CE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [12:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    req_valid[ch]         = 1'b1;
    req_write[ch]         = wr;
    req_addr[ch*13 +: 13] = a;
    req_wdata[ch*32 +: 32] = d;
    req_be[ch*4 +: 4]     = be;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] exp_g;

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    clr_all();

    // ---------------- reset values ----------------
    #3;
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 13'h0, 32'h0, 4'h0);
    #1;
    check_value("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
    check_value("rst_ce", {31'h0, CE}, 32'h0);
    check_value("rst_rdata", rsp_rdata, 32'h0);
    check_value("rst_ready", {28'h0, req_ready}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check_value("first_grant_ch0", {28'h0, req_ready}, 32'h1);

    // ---------------- round-robin, all valid ----------------
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      check_value("rr_ready", {28'h0, req_ready}, {28'h0, exp_g});
      tick();
      check_value("rr_rsp_valid", {28'h0, rsp_valid}, {28'h0, exp_g});
    end
    // two more grants, then ch2 drops out
    check_value("rr2_ready0", {28'h0, req_ready}, 32'h1);
    tick();
    check_value("rr2_ready1", {28'h0, req_ready}, 32'h2);
    tick();
    req_valid[2] = 1'b0;
    #1;
    check_value("skip2_ready3", {28'h0, req_ready}, 32'h8);
    tick();
    check_value("skip2_ready0", {28'h0, req_ready}, 32'h1);
    tick();
    check_value("skip2_ready1", {28'h0, req_ready}, 32'h2);
    tick();
    check_value("skip2_ready3b", {28'h0, req_ready}, 32'h8);
    tick();
    clr_all();

    // ---------------- single channel write/read at top address ----------------
    set_ch(1, 1'b1, 13'h1FFF, 32'hDEADBEEF, 4'hF);
    #1;
    check_value("wr1_ready", {28'h0, req_ready}, 32'h2);
    tick();
    check_value("wr1_rsp_valid", {28'h0, rsp_valid}, 32'h2);
    check_value("wr1_ce", {31'h0, CE}, 32'h1);
    clr_all();
    set_ch(1, 1'b0, 13'h1FFF, 32'h0, 4'h0);
    tick();
    check_value("rd1_rsp_valid", {28'h0, rsp_valid}, 32'h2);
    check_value("rd1_rdata", rsp_rdata, 32'hDEADBEEF);
    check_value("rd1_ce", {31'h0, CE}, 32'h1);
    clr_all();

    // ---------------- byte enables ----------------
    set_ch(0, 1'b1, 13'h0100, 32'h11223344, 4'hF);
    tick();
    set_ch(0, 1'b1, 13'h0100, 32'hAABBCCDD, 4'b0101);
    tick();
    check_value("be_old_data", rsp_rdata, 32'h11223344);
    check_value("be_rsp_valid", {28'h0, rsp_valid}, 32'h1);
    set_ch(0, 1'b0, 13'h0100, 32'h0, 4'h0);
    tick();
    check_value("be_merged", rsp_rdata, 32'h11BB33DD);
    // be=0 write is acknowledged but changes nothing
    set_ch(0, 1'b1, 13'h0100, 32'hFFFFFFFF, 4'h0);
    tick();
    check_value("be0_rsp_valid", {28'h0, rsp_valid}, 32'h1);
    check_value("be0_old", rsp_rdata, 32'h11BB33DD);
    set_ch(0, 1'b0, 13'h0100, 32'h0, 4'h0);
    tick();
    check_value("be0_unchanged", rsp_rdata, 32'h11BB33DD);
    clr_all();

    // ---------------- idle and hold ----------------
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("idle_ce", {31'h0, CE}, 32'h0);
      check_value("idle_rsp_valid", {28'h0, rsp_valid}, 32'h0);
      check_value("idle_rdata_hold", rsp_rdata, 32'h11BB33DD);
    end
    set_ch(3, 1'b0, 13'h1FFF, 32'h0, 4'h0);
    #1;
    check_value("ch3_ready", {28'h0, req_ready}, 32'h8);
    tick();
    check_value("ch3_rsp_valid", {28'h0, rsp_valid}, 32'h8);
    check_value("ch3_rdata", rsp_rdata, 32'hDEADBEEF);
    clr_all();

    // ---------------- back-to-back write then read ----------------
    set_ch(0, 1'b1, 13'd7, 32'h00000005, 4'hF);
    tick();
    clr_all();
    set_ch(1, 1'b0, 13'd7, 32'h0, 4'h0);
    #1;
    check_value("b2b_ready", {28'h0, req_ready}, 32'h2);
    tick();
    check_value("b2b_rsp_valid", {28'h0, rsp_valid}, 32'h2);
    check_value("b2b_rdata", rsp_rdata, 32'h00000005);
    clr_all();

    // ---------------- async reset with a response in flight ----------------
    set_ch(2, 1'b0, 13'd7, 32'h0, 4'h0);
    tick();
    check_value("inflight_rsp_valid", {28'h0, rsp_valid}, 32'h4);
    #2;
    RESET = 1'b1;
    #1;
    check_value("arst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
    check_value("arst_ce", {31'h0, CE}, 32'h0);
    check_value("arst_rdata", rsp_rdata, 32'h0);
    check_value("arst_ready", {28'h0, req_ready}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 13'h0, 32'h0, 4'h0);
    RESET = 1'b0;
    #1;
    check_value("post_rst_ch0", {28'h0, req_ready}, 32'h1);
    tick();
    check_value("post_rst_rsp0", {28'h0, rsp_valid}, 32'h1);
    check_value("post_rst_ready1", {28'h0, req_ready}, 32'h2);
    clr_all();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
